// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for slave-side blocks.
//   - channel A / channel D opcode encodings
//   - tl_a_req_t: one captured channel A request
//   - default bus widths
package tl_pkg;

  localparam int TL_ADDR_W = 12;
  localparam int TL_DATA_W = 32;
  localparam int TL_MASK_W = TL_DATA_W / 8;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // opcode is kept as raw bits so that illegal requests can be held too
  typedef struct packed {
    logic [2:0]           opcode;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_DATA_W-1:0] data;
    logic [1:0]           size;
    logic [TL_MASK_W-1:0] mask;
  } tl_a_req_t;

endpackage

// File: rtl/tl_req_check.sv
// Combinational legality check for a TileLink-UL channel A request.
//   opcode_i   : channel A opcode
//   addr_lsb_i : two least significant byte-address bits
//   size_i     : log2 of the access size in bytes
//   mask_i     : byte lane mask
//   denied_o   : 1 when the request must be answered with a denied response
module tl_req_check
  import tl_pkg::*;
#(
  parameter int MASK_W = TL_MASK_W
) (
  input  logic [2:0]        opcode_i,
  input  logic [1:0]        addr_lsb_i,
  input  logic [1:0]        size_i,
  input  logic [MASK_W-1:0] mask_i,
  output logic              denied_o
);

  logic op_bad;
  logic size_bad;
  logic misaligned;
  logic empty_partial;

  always_comb begin
    op_bad = !((opcode_i == PUT_FULL) || (opcode_i == PUT_PARTIAL) || (opcode_i == GET));
    size_bad = (size_i == 2'd3);
    case (size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_lsb_i[0];
      default: misaligned = |addr_lsb_i;
    endcase
    empty_partial = (opcode_i == PUT_PARTIAL) && (mask_i == '0);
    denied_o = op_bad | size_bad | misaligned | empty_partial;
  end

endmodule

// File: rtl/tl_ul_slave_adapter.sv
// TileLink-UL slave endpoint in front of a synchronous single-port memory.
// One transaction at a time: accept channel A, do one memory access,
// return AccessAck / AccessAckData (or a denied AccessAck) on channel D.
//   clk_i, rst_i            : clock, async active-high reset
//   a_*                     : channel A request from the host
//   d_*                     : channel D response to the host
//   mem_*                   : memory port, rdata valid the cycle after mem_req_o
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | a_ready_o high, waiting for a channel A request
// ST_ACCESS  | memory strobe driven for exactly one cycle
// ST_CAPTURE | read data returning from memory is latched
// ST_RESP    | d_valid_o held with stable fields until d_ready_i
module tl_ul_slave_adapter
  import tl_pkg::*;
#(
  parameter int ADDR_W = TL_ADDR_W,
  parameter int DATA_W = TL_DATA_W,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [2:0]        a_opcode_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [1:0]        a_size_i,
  input  logic [MASK_W-1:0] a_mask_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [2:0]        d_opcode_o,
  output logic [1:0]        d_size_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_denied_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [MASK_W-1:0] mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  tl_a_req_t         req_q, req_d;
  logic              a_ready_q, a_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              d_valid_q, d_valid_d;
  logic [2:0]        d_opcode_q, d_opcode_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              d_denied_q, d_denied_d;
  logic              denied;
  logic              is_get;

  tl_req_check #(.MASK_W(MASK_W)) u_req_check (
    .opcode_i   (a_opcode_i),
    .addr_lsb_i (a_address_i[1:0]),
    .size_i     (a_size_i),
    .mask_i     (a_mask_i),
    .denied_o   (denied)
  );

  assign is_get = (a_opcode_i == GET);

  // The address/data/mask fields of req_q double as the memory command
  // register: they hold the memory-side view only while in ST_ACCESS and are
  // zero otherwise, so the memory port is flop-driven and idle outside it.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    a_ready_d  = a_ready_q;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_data_d   = d_data_q;
    d_denied_d = d_denied_q;
    case (state_q)
      ST_IDLE: begin
        if (a_valid_i && a_ready_q) begin
          a_ready_d     = 1'b0;
          req_d         = '0;
          req_d.opcode  = a_opcode_i;
          req_d.size    = a_size_i;
          if (denied) begin
            state_d    = ST_RESP;
            d_valid_d  = 1'b1;
            d_denied_d = 1'b1;
            d_opcode_d = ACCESS_ACK;
            d_data_d   = '0;
          end else begin
            state_d       = ST_ACCESS;
            mem_req_d     = 1'b1;
            mem_we_d      = !is_get;
            req_d.address = a_address_i;
            req_d.data    = is_get ? '0 : a_data_i;
            req_d.mask    = is_get ? '0 : a_mask_i;
          end
        end
      end
      ST_ACCESS: begin
        state_d       = ST_CAPTURE;
        req_d.address = '0;
        req_d.data    = '0;
        req_d.mask    = '0;
      end
      ST_CAPTURE: begin
        state_d    = ST_RESP;
        d_valid_d  = 1'b1;
        d_denied_d = 1'b0;
        if (req_q.opcode == GET) begin
          d_opcode_d = ACCESS_ACK_DATA;
          d_data_d   = mem_rdata_i;
        end else begin
          d_opcode_d = ACCESS_ACK;
          d_data_d   = '0;
        end
      end
      ST_RESP: begin
        if (d_ready_i) begin
          state_d    = ST_IDLE;
          a_ready_d  = 1'b1;
          req_d      = '0;
          d_valid_d  = 1'b0;
          d_denied_d = 1'b0;
          d_opcode_d = ACCESS_ACK;
          d_data_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      a_ready_q  <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_data_q   <= '0;
      d_denied_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      a_ready_q  <= a_ready_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_data_q   <= d_data_d;
      d_denied_q <= d_denied_d;
    end
  end

  // byte-offset bits are only needed by the legality check at accept time
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_q.address[1:0];

  assign a_ready_o   = a_ready_q;
  assign d_valid_o   = d_valid_q;
  assign d_opcode_o  = d_opcode_q;
  assign d_size_o    = req_q.size;
  assign d_data_o    = d_data_q;
  assign d_denied_o  = d_denied_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = req_q.address[ADDR_W-1:2];
  assign mem_wdata_o = req_q.data;
  assign mem_be_o    = req_q.mask;

endmodule

// File: tb/tb_tl_ul_slave_adapter.sv
// Bench for tl_ul_slave_adapter: table of single transactions with
// cycle-exact channel A / memory checks, a scoreboard queue matched against
// channel D handshakes, plus backpressure and async-reset sequences.
`timescale 1ns/1ps
module tb_tl_ul_slave_adapter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a_valid_i;
  logic        a_ready_o;
  logic [2:0]  a_opcode_i;
  logic [11:0] a_address_i;
  logic [31:0] a_data_i;
  logic [1:0]  a_size_i;
  logic [3:0]  a_mask_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_size_o;
  logic [31:0] d_data_o;
  logic        d_denied_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  tl_ul_slave_adapter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
    .a_address_i(a_address_i), .a_data_i(a_data_i), .a_size_i(a_size_i),
    .a_mask_i(a_mask_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
    .d_size_o(d_size_o), .d_data_o(d_data_o), .d_denied_o(d_denied_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        deny;
    logic        we;
    logic [9:0]  maddr;
    logic [3:0]  be;
    logic [2:0]  dop;
    logic [31:0] ddata;
  } vec_t;

  typedef struct {
    logic [2:0]  dop;
    logic [31:0] ddata;
    logic [1:0]  size;
    logic        deny;
  } resp_t;

  vec_t  vecs[$];
  resp_t exp_q[$];
  resp_t mon_r;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] data,
                         input logic [1:0] size, input logic [3:0] mask);
    a_valid_i   = 1'b1;
    a_opcode_i  = op;
    a_address_i = addr;
    a_data_i    = data;
    a_size_i    = size;
    a_mask_i    = mask;
  endtask

  // One transaction with d_ready_i high; entered and left on a negedge while idle.
  task automatic send(input vec_t v);
    chk("a_ready_before", a_ready_o, 1);
    drive_a(v.op, v.addr, v.data, v.size, v.mask);
    exp_q.push_back('{v.dop, v.ddata, v.size, v.deny});
    @(negedge clk_i);                        // cycle 1
    a_valid_i = 1'b0;
    chk("a_ready_busy", a_ready_o, 0);
    if (v.deny) begin
      chk("deny_mem_req_c1", mem_req_o, 0);
      chk("deny_d_valid_c1", d_valid_o, 1);
    end else begin
      chk("mem_req_c1", mem_req_o, 1);
      chk("mem_we_c1", mem_we_o, v.we);
      chk("mem_addr_c1", mem_addr_o, v.maddr);
      chk("mem_be_c1", mem_be_o, v.be);
      if (v.we) chk("mem_wdata_c1", mem_wdata_o, v.data);
      chk("d_valid_c1", d_valid_o, 0);
      @(negedge clk_i);                      // cycle 2: memory answers now
      chk("mem_req_c2", mem_req_o, 0);
      chk("d_valid_c2", d_valid_o, 0);
      mem_rdata_i = v.rdata;
      @(negedge clk_i);                      // cycle 3
      mem_rdata_i = JUNK;
      chk("mem_req_c3", mem_req_o, 0);
      chk("d_valid_c3", d_valid_o, 1);
    end
    @(negedge clk_i);
    chk("d_valid_after", d_valid_o, 0);
    chk("a_ready_after", a_ready_o, 1);
  endtask

  // Scoreboard side: a D handshake is decided by values present just before
  // the next posedge, so sample a little after the negedge drive point.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i && d_valid_o && d_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d_unexpected actual=response required=none");
        end else begin
          mon_r = exp_q.pop_front();
          chk("d_opcode", d_opcode_o, mon_r.dop);
          chk("d_data", d_data_o, mon_r.ddata);
          chk("d_size", d_size_o, mon_r.size);
          chk("d_denied", d_denied_o, mon_r.deny);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    a_valid_i = 1'b0; a_opcode_i = '0; a_address_i = '0; a_data_i = '0;
    a_size_i = '0; a_mask_i = '0; d_ready_i = 1'b1; mem_rdata_i = JUNK;

    //           op    addr     data          sz  mask  rdata         deny we maddr   be    dop   ddata
    vecs.push_back('{3'd4, 12'h010, 32'h0,        2, 4'hF, 32'hDEADBEEF, 0, 0, 10'h004, 4'h0, 3'd1, 32'hDEADBEEF});
    vecs.push_back('{3'd0, 12'h020, 32'h12345678, 2, 4'hF, JUNK,         0, 1, 10'h008, 4'hF, 3'd0, 32'h0});
    vecs.push_back('{3'd1, 12'h002, 32'hAABB0000, 1, 4'hC, JUNK,         0, 1, 10'h000, 4'hC, 3'd0, 32'h0});
    vecs.push_back('{3'd1, 12'h002, 32'hAABB0000, 1, 4'h0, JUNK,         1, 0, 10'h000, 4'h0, 3'd0, 32'h0});
    vecs.push_back('{3'd4, 12'h003, 32'h0,        2, 4'hF, JUNK,         1, 0, 10'h000, 4'h0, 3'd0, 32'h0});
    vecs.push_back('{3'd5, 12'h000, 32'h0,        2, 4'hF, JUNK,         1, 0, 10'h000, 4'h0, 3'd0, 32'h0});
    vecs.push_back('{3'd2, 12'h000, 32'h0,        2, 4'hF, JUNK,         1, 0, 10'h000, 4'h0, 3'd0, 32'h0});
    vecs.push_back('{3'd4, 12'h000, 32'h0,        3, 4'hF, JUNK,         1, 0, 10'h000, 4'h0, 3'd0, 32'h0});
    vecs.push_back('{3'd4, 12'h005, 32'h0,        1, 4'h3, JUNK,         1, 0, 10'h000, 4'h0, 3'd0, 32'h0});
    vecs.push_back('{3'd4, 12'hFFC, 32'h0,        2, 4'hF, 32'h0BADF00D, 0, 0, 10'h3FF, 4'h0, 3'd1, 32'h0BADF00D});
    vecs.push_back('{3'd4, 12'h006, 32'h0,        1, 4'hC, 32'h11223344, 0, 0, 10'h001, 4'h0, 3'd1, 32'h11223344});
    vecs.push_back('{3'd0, 12'h007, 32'hEE000000, 0, 4'h8, JUNK,         0, 1, 10'h001, 4'h8, 3'd0, 32'h0});
    vecs.push_back('{3'd0, 12'h030, 32'h0F0F0F0F, 2, 4'h0, JUNK,         0, 1, 10'h00C, 4'h0, 3'd0, 32'h0});
    vecs.push_back('{3'd7, 12'h000, 32'h0,        0, 4'h1, JUNK,         1, 0, 10'h000, 4'h0, 3'd0, 32'h0});

    repeat (2) @(negedge clk_i);
    chk("rst_a_ready", a_ready_o, 1);
    chk("rst_d_valid", d_valid_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_d_data", d_data_o, 0);
    chk("rst_d_opcode", d_opcode_o, 0);
    chk("rst_d_denied", d_denied_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    foreach (vecs[i]) send(vecs[i]);

    // Backpressure: response held for several cycles, second request waits.
    d_ready_i = 1'b0;
    drive_a(3'd4, 12'h040, 32'h0, 2, 4'hF);
    exp_q.push_back('{3'd1, 32'hCAFEF00D, 2'd2, 1'b0});
    @(negedge clk_i);
    a_valid_i = 1'b0;
    chk("bp_mem_req", mem_req_o, 1);
    chk("bp_mem_addr", mem_addr_o, 10'h010);
    @(negedge clk_i);
    mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    mem_rdata_i = JUNK;
    drive_a(3'd0, 12'h044, 32'h55AA55AA, 2, 4'hF);
    for (int k = 0; k < 4; k++) begin
      chk("bp_d_valid", d_valid_o, 1);
      chk("bp_d_data", d_data_o, 32'hCAFEF00D);
      chk("bp_d_opcode", d_opcode_o, 1);
      chk("bp_a_ready", a_ready_o, 0);
      chk("bp_mem_req_idle", mem_req_o, 0);
      @(negedge clk_i);
    end
    d_ready_i = 1'b1;
    exp_q.push_back('{3'd0, 32'h0, 2'd2, 1'b0});
    @(negedge clk_i);
    chk("bp_a_ready_after", a_ready_o, 1);
    chk("bp_d_valid_after", d_valid_o, 0);
    chk("bp_no_early_accept", mem_req_o, 0);
    @(negedge clk_i);
    a_valid_i = 1'b0;
    chk("bp2_mem_req", mem_req_o, 1);
    chk("bp2_mem_we", mem_we_o, 1);
    chk("bp2_mem_addr", mem_addr_o, 10'h011);
    chk("bp2_mem_wdata", mem_wdata_o, 32'h55AA55AA);
    repeat (2) @(negedge clk_i);
    chk("bp2_d_valid", d_valid_o, 1);
    @(negedge clk_i);
    chk("bp2_idle", a_ready_o, 1);

    // Asynchronous reset while a Get sits in CAPTURE.
    drive_a(3'd4, 12'h080, 32'h0, 2, 4'hF);
    exp_q.push_back('{3'd1, 32'h13579BDF, 2'd2, 1'b0});
    @(negedge clk_i);
    a_valid_i = 1'b0;
    @(negedge clk_i);
    mem_rdata_i = 32'h13579BDF;
    #1 rst_i = 1'b1;
    #1;
    void'(exp_q.pop_back());
    chk("arst_a_ready", a_ready_o, 1);
    chk("arst_d_valid", d_valid_o, 0);
    chk("arst_mem_req", mem_req_o, 0);
    chk("arst_d_data", d_data_o, 0);
    chk("arst_d_size", d_size_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_rdata_i = JUNK;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("arst_no_resp", d_valid_o, 0);
      chk("arst_ready", a_ready_o, 1);
    end

    send('{3'd4, 12'h100, 32'h0, 2, 4'hF, 32'h2468ACE0, 0, 0, 10'h040, 4'h0, 3'd1, 32'h2468ACE0});

    repeat (2) @(negedge clk_i);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
